// File: rtl/rr_arb_pkg.sv
// Shared types and the round-robin pick function used by the burst arbiter.
package rr_arb_pkg;

    typedef enum logic {StIdle, StBusy} state_e;

    localparam int unsigned DefaultN        = 4;
    localparam int unsigned DefaultMaxBurst = 8;
    localparam int unsigned MaxN            = 16;
    localparam int unsigned MaxIdW          = 4;

    typedef struct packed {
        logic              found;
        logic [MaxIdW-1:0] idx;
    } pick_t;

    // Scan from ptr upward modulo n; the first unmasked request wins.
    function automatic pick_t rr_pick(input logic [MaxN-1:0]   req,
                                      input logic [MaxIdW-1:0] ptr,
                                      input logic [MaxN-1:0]   mask,
                                      input int unsigned       n);
        pick_t       r;
        int unsigned s;
        r = '0;
        for (int unsigned k = 0; k < MaxN; k++) begin
            s = k + 32'(ptr);
            if (s >= n) s = s - n;
            if (k < n && !r.found && req[s] && !mask[s]) begin
                r.found = 1'b1;
                r.idx   = s[MaxIdW-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating find-first: highest priority at ptr, lowest at ptr-1 mod N.
module rr_priority_pick
    import rr_arb_pkg::*;
#(
    parameter int unsigned N    = DefaultN,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic [N-1:0]    mask,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    pick_t p;

    always_comb begin
        p     = rr_pick(MaxN'(req), MaxIdW'(ptr), MaxN'(mask), N);
        found = p.found;
        idx   = ID_W'(p.idx);
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: holds a grant for a burst, releases on last beat,
// burst cap or abandon, then rotates priority past the released requester.
module rr_burst_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned N         = DefaultN,
    parameter int unsigned MAX_BURST = DefaultMaxBurst,
    parameter int unsigned BURST_W   = 4,
    parameter int unsigned ID_W      = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       req_last,
    input  logic               res_ready,
    output logic [N-1:0]       grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic [BURST_W-1:0] beat_cnt,
    output logic               burst_done
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [BURST_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;

    logic               busy, owner_req, beat, rel_abandon, release_now;
    logic [ID_W-1:0]    ptr_after, pick_ptr, pick_idx;
    logic [N-1:0]       pick_mask;
    logic               pick_found;

    always_comb begin
        busy        = (state_q == StBusy);
        owner_req   = req[id_q];
        beat        = busy && owner_req && res_ready;
        rel_abandon = busy && !owner_req;
        release_now = rel_abandon ||
                      (beat && (req_last[id_q] || cnt_q == BURST_W'(MAX_BURST - 1)));
        ptr_after   = (id_q == ID_W'(N - 1)) ? '0 : id_q + ID_W'(1);
        // While busy the pick is only consumed on release, so it always uses the rotated ptr.
        pick_ptr    = busy ? ptr_after : ptr_q;
        pick_mask   = '0;
        if (rel_abandon) pick_mask[id_q] = 1'b1;
    end

    rr_priority_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d          = StBusy;
                    grant_d          = '0;
                    grant_d[pick_idx] = 1'b1;
                    id_d             = pick_idx;
                    cnt_d            = '0;
                end
            end
            StBusy: begin
                if (release_now) begin
                    ptr_d  = ptr_after;
                    done_d = 1'b1;
                    cnt_d  = '0;
                    grant_d = '0;
                    if (pick_found) begin
                        grant_d[pick_idx] = 1'b1;
                        id_d              = pick_idx;
                    end else begin
                        state_d = StIdle;
                        id_d    = '0;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + BURST_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            grant_q <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = id_q;
    assign beat_cnt    = cnt_q;
    assign burst_done  = done_q;

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
Round-robin arbiter that shares one single-port resource between N requesters. Once a requester wins, it keeps the grant for a whole burst of beats. The grant is released on the requester's last beat, when the burst hits the MAX_BURST cap, or when the requester drops its request. Priority then rotates to the index after the released one. The block sits between the requester ports and the resource mux, and drives the mux select and the beat accounting.

Parameters:
N, 4, number of requesters (2..16)
MAX_BURST, 8, maximum beats per grant before forced release (1..2^BURST_W-1)
BURST_W, 4, width of the beat counter
ID_W, $clog2(N), width of grant_id

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active high
req  in  N  per-requester request level; held while the requester wants the resource
req_last  in  N  per-requester flag; marks the current beat as the final beat of its burst
res_ready  in  1  resource accepts a beat this cycle
grant  out  N  registered one-hot grant; all zero when idle
grant_valid  out  1  registered; equals |grant
grant_id  out  ID_W  registered binary index of the granted requester; 0 when idle
beat_cnt  out  BURST_W  registered count of beats accepted in the current burst
burst_done  out  1  registered one-cycle pulse, asserted the cycle after a release

Behaviour:
- Reset (rst=1 at a clk edge):
  - grant=0, grant_valid=0, grant_id=0, beat_cnt=0, burst_done=0.
  - state=IDLE, priority pointer ptr=0.
  - Reset mid-burst aborts the burst; no burst_done is generated.
- States: IDLE, BUSY.
- Beat definition: beat = BUSY && req[grant_id] && res_ready.
- Arbitration (combinational select, registered result):
  - Scan the request vector starting at index ptr, wrapping modulo N.
  - The first set req wins.
  - ptr itself has the highest priority; ptr-1 (mod N) has the lowest.
- IDLE:
  - If req != 0, the winner is registered. The next cycle has grant one-hot, grant_valid=1, beat_cnt=0, state=BUSY.
  - Latency from req assertion to grant is 1 cycle.
  - If req == 0, stay in IDLE.
- BUSY, non-release beat: beat_cnt increments by 1.
- BUSY, release conditions (evaluated each cycle):
  - (a) beat && req_last[grant_id];
  - (b) beat && beat_cnt == MAX_BURST-1;
  - (c) !req[grant_id] (abandon; no beat counted).
- On release:
  - ptr <= (grant_id+1) mod N.
  - Re-arbitrate in the same cycle with that new ptr, masking out the releasing index only in case (c).
  - If a winner exists, the next cycle grants it directly with no idle bubble, beat_cnt=0, state stays BUSY.
  - Otherwise the next cycle has grant=0 and state=IDLE.
  - burst_done=1 in the next cycle, for cases (a), (b) and (c).
- While BUSY without a release, the grant is stable. Requests from other indices are ignored until release.
- req_last on a non-beat cycle (res_ready=0) has no effect.
- The releasing requester may be re-granted only if it is the sole requester. Because ptr rotates past it, it has the lowest priority.
- No arithmetic overflow: beat_cnt never exceeds MAX_BURST-1, because release (b) fires first.
- req bits of non-granted requesters may toggle freely; there is no protocol obligation on them.

Decomposition:
- Shared package rr_arb_pkg:
  - state enum (IDLE, BUSY);
  - default N / MAX_BURST constants;
  - function rr_pick(req, ptr, mask), returning a found flag and an index.
- One natural sub-module, rr_priority_pick:
  - purely combinational rotate, find-first, unrotate;
  - parameterised by N;
  - instantiated once.
- Top level holds the FSM, ptr, beat counter and output registers.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst=1 for 2 cycles with req=4'b1111, then release rst.
  - Response: while rst=1, grant=0, grant_valid=0, beat_cnt=0. One cycle after rst drops, grant=4'b0001, grant_id=0.
- Rotation:
  - Stimulus: req=4'b1111 constant, res_ready=1, req_last=4'b1111.
  - Response: grants go 0001, 0010, 0100, 1000, 0001, with one beat each. burst_done pulses every cycle from the second grant onward. There are no idle cycles.
- Burst cap:
  - Stimulus: req=4'b0011, req_last=0, res_ready=1.
  - Response: requester 0 holds for exactly 8 cycles, with beat_cnt 0..7. Then grant=0010 with beat_cnt=0, and burst_done=1 on that same cycle.
- Backpressure:
  - Stimulus: requester 2 is granted; res_ready alternates 1,0,1,0; req_last[2]=1 asserted on the 3rd cycle, which is a res_ready=1 cycle.
  - Response: beat_cnt goes 0, 1, 1, then releases. A req_last asserted only on a res_ready=0 cycle causes no release.
- Abandon:
  - Stimulus: requester 1 is granted at beat_cnt=3; req[1] drops; req=4'b1000.
  - Response: next cycle grant=1000, beat_cnt=0, burst_done=1. Since ptr=2, requester 3 beats requester 0 if both request.
- Reset mid-burst:
  - Stimulus: rst=1 while BUSY with grant=0100.
  - Response: next cycle all outputs are 0 and there is no burst_done pulse. With req=4'b0101 after reset, requester 0 wins (ptr=0).
